// File: rtl/combi_encoder.sv
// Encodes RISC-V / ARM instruction descriptors into 32-bit words behind a 2-entry output queue.
// Latency 1 from accept to out_valid; in_ready depends only on occupancy and flush.
module combi_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_isa,
    input  logic [2:0]  in_cls,
    input  logic [2:0]  in_alu,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_cond,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_isa,
    output logic [1:0]  count,
    output logic        err,
    output logic [7:0]  err_cnt
);
    localparam logic [2:0] CLS_ALUR = 3'd0;
    localparam logic [2:0] CLS_ALUI = 3'd1;
    localparam logic [2:0] CLS_LD   = 3'd2;
    localparam logic [2:0] CLS_ST   = 3'd3;
    localparam logic [2:0] CLS_BR   = 3'd4;
    localparam logic [2:0] ALU_SUB  = 3'd1;

    logic [32:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]  count_q, count_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic signed [31:0] imm_s;
    logic [31:0] mag;
    logic [31:0] enc;
    logic        legal, alu_ok, imm12_ok, acc, push, pop;
    logic [2:0]  rv_f3;
    logic [3:0]  arm_opc;

    assign imm_s = in_imm;

    always_comb begin
        mag      = (imm_s < 0) ? (32'd0 - in_imm) : in_imm;
        alu_ok   = (in_alu <= 3'd4);
        imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
        case (in_alu)
            3'd0:    begin rv_f3 = 3'b000; arm_opc = 4'b0100; end
            3'd1:    begin rv_f3 = 3'b000; arm_opc = 4'b0010; end
            3'd2:    begin rv_f3 = 3'b111; arm_opc = 4'b0000; end
            3'd3:    begin rv_f3 = 3'b110; arm_opc = 4'b1100; end
            3'd4:    begin rv_f3 = 3'b100; arm_opc = 4'b0001; end
            default: begin rv_f3 = 3'b000; arm_opc = 4'b0000; end
        endcase
        enc   = '0;
        legal = 1'b0;
        if (!in_isa) begin
            case (in_cls)
                CLS_ALUR: begin
                    legal = alu_ok;
                    enc   = {(in_alu == ALU_SUB) ? 7'b0100000 : 7'b0000000,
                             in_rs2, in_rs1, rv_f3, in_rd, 7'b0110011};
                end
                CLS_ALUI: begin
                    legal = alu_ok && (in_alu != ALU_SUB) && imm12_ok;
                    enc   = {in_imm[11:0], in_rs1, rv_f3, in_rd, 7'b0010011};
                end
                CLS_LD: begin
                    legal = imm12_ok;
                    enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                end
                CLS_ST: begin
                    legal = imm12_ok;
                    enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                end
                CLS_BR: begin
                    legal = !in_imm[0] && (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
                    enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, in_cond[0],
                             in_imm[4:1], in_imm[11], 7'b1100011};
                end
                default: ;
            endcase
        end else begin
            // ARM has 16 registers; bit 4 of any register the class reads or writes is illegal.
            case (in_cls)
                CLS_ALUR: begin
                    legal = alu_ok && !in_rd[4] && !in_rs1[4] && !in_rs2[4];
                    enc   = {in_cond, 3'b000, arm_opc, 1'b0, in_rs1[3:0], in_rd[3:0], 8'h00, in_rs2[3:0]};
                end
                CLS_ALUI: begin
                    legal = alu_ok && !in_rd[4] && !in_rs1[4] && (imm_s >= 0) && (imm_s <= 32'sd255);
                    enc   = {in_cond, 3'b001, arm_opc, 1'b0, in_rs1[3:0], in_rd[3:0], 4'h0, in_imm[7:0]};
                end
                CLS_LD: begin
                    legal = !in_rd[4] && !in_rs1[4] && (mag <= 32'd4095);
                    enc   = {in_cond, 4'b0101, !in_imm[31], 2'b00, 1'b1, in_rs1[3:0], in_rd[3:0], mag[11:0]};
                end
                CLS_ST: begin
                    legal = !in_rs2[4] && !in_rs1[4] && (mag <= 32'd4095);
                    enc   = {in_cond, 4'b0101, !in_imm[31], 2'b00, 1'b0, in_rs1[3:0], in_rs2[3:0], mag[11:0]};
                end
                CLS_BR: begin
                    legal = (in_imm[1:0] == 2'b00) && (imm_s >= -32'sd33554432) && (imm_s <= 32'sd33554428);
                    enc   = {in_cond, 4'b1010, in_imm[25:2]};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (count_q < 2'd2) && !flush;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = slot0_q[31:0];
    assign out_isa   = slot0_q[32];
    assign count     = count_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    assign acc  = in_valid && in_ready;
    assign push = acc && legal;
    assign pop  = out_valid && out_ready;

    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        count_d   = count_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop)
                slot0_d = slot1_q;
            // The new word lands at the head when the queue is empty or is being drained to empty.
            if (push) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && pop))
                    slot0_d = {in_isa, enc};
                else
                    slot1_d = {in_isa, enc};
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
        if (acc && !legal) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hff)
                err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot0_q   <= '0;
            slot1_q   <= '0;
            count_q   <= 2'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            count_q   <= count_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: doc/combi_encoder.md
COMBI_ENCODER -- requirements
Module: combi_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 flush  in  1  synchronous queue clear.
REQ-004 in_valid  in  1  descriptor valid.
REQ-005 in_ready  out  1  encoder can accept a descriptor this cycle.
REQ-006 in_isa  in  1  0 = RISC-V, 1 = ARM.
REQ-007 in_cls  in  3  class: 0 ALUR, 1 ALUI, 2 LD, 3 ST, 4 BR; 5-7 illegal.
REQ-008 in_alu  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; 5-7 illegal; used only when in_cls is ALUR or ALUI.
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-010 in_imm  in  32  signed immediate or byte offset.
REQ-011 in_cond  in  4  ARM condition field; RISC-V BR uses bit 0 only (0 BEQ, 1 BNE).
REQ-012 out_valid  out  1  encoded word available.
REQ-013 out_ready  in  1  consumer takes the word.
REQ-014 out_instr  out  32  encoded instruction.
REQ-015 out_isa  out  1  ISA tag of out_instr.
REQ-016 count  out  2  queue occupancy, 0-2.
REQ-017 err  out  1  sticky illegal-descriptor flag.
REQ-018 err_cnt  out  8  saturating count of dropped descriptors.

Function
REQ-019 Accept occurs when in_valid and in_ready are both high on a rising edge.
REQ-020 in_ready SHALL equal (count < 2) and not flush; there is no combinational pass-through from out_ready.
REQ-021 On an accepted legal descriptor, the encoded word SHALL be pushed into a 2-entry FIFO at that edge; out_valid is high the following cycle (latency 1).
REQ-022 The FIFO head is popped when out_valid and out_ready are both high; out_instr and out_isa stay stable while out_valid is high and out_ready is low.
REQ-023 Push and pop in the same cycle at count 1 SHALL leave count at 1, with the new word behind the popped one; at count 2 no push is possible.
REQ-024 flush SHALL set count to 0 at the edge, discard any same-cycle accept, and leave err/err_cnt unchanged.
REQ-025 RISC-V ALUR: funct7 = 0100000 for SUB, else 0; funct3 ADD/SUB 000, AND 111, OR 110, XOR 100; opcode 0110011.
REQ-026 RISC-V ALUI: imm[11:0], same funct3, opcode 0010011; SUB is illegal.
REQ-027 RISC-V LD: I-type, funct3 010, opcode 0000011.
REQ-028 RISC-V ST: S-type, funct3 010, opcode 0100011.
REQ-029 RISC-V I-type and S-type immediates SHALL lie in -2048..2047.
REQ-030 RISC-V BR: B-type, opcode 1100011, funct3 = {00, in_cond[0]}; in_imm SHALL be even and lie in -4096..4094.
REQ-031 ARM non-branch classes SHALL use cond = in_cond and S = 0.
REQ-032 ARM ALUR: 00 0 opcode 0 Rn=rs1 Rd=rd 00000000 Rm=rs2.
REQ-033 ARM ALUI: 00 1 opcode 0 Rn Rd 0000 imm8; in_imm SHALL lie in 0..255.
REQ-034 ARM ALU opcodes: AND 0000, EOR 0001, SUB 0010, ADD 0100, ORR 1100.
REQ-035 ARM LD/ST: 01 0 1 U 0 0 L Rn=rs1 Rd imm12; U = (in_imm >= 0); offset = |in_imm| <= 4095; L = 1 for LD (Rd = rd), L = 0 for ST (Rd = rs2).
REQ-036 ARM BR: cond 1010 imm24 = in_imm[25:2]; in_imm SHALL be word-aligned and lie in -2^25..2^25-4.
REQ-037 For ARM, any used register index with bit 4 set is illegal.
REQ-038 An illegal descriptor (bad class, bad ALU op, range violation, misalignment, bad register) is accepted and consumed but not pushed; it sets err and increments err_cnt, which saturates at 255.

Reset
REQ-039 While reset_n is low: count = 0, out_valid = 0, out_instr = 0, out_isa = 0, err = 0, err_cnt = 0; in_ready is high one cycle after release.
REQ-040 Reset mid-operation discards all queued words immediately and asynchronously.

Verification
REQ-041 RISC-V ALUR SUB, rd=3, rs1=1, rs2=2 -> out_instr 0x402081B3 one cycle later.
REQ-042 ARM LD, cond=E, rd=0, rs1=1, imm=-4 -> out_instr 0xE5110004.
REQ-043 Push 3 descriptors with out_ready=0 -> count=2, in_ready=0, third not accepted; then out_ready=1 -> words emerge in order.
REQ-044 RISC-V ALUI imm=2048 -> no output, err=1, err_cnt=1; 256 further illegal descriptors -> err_cnt=255.
REQ-045 count=2 with flush and a valid descriptor in the same cycle -> count=0, out_valid=0 next cycle, err unchanged.
REQ-046 Assert reset_n low while count=1 -> out_valid drops without waiting for a clock edge.
